// File: rtl/packed_sub_seq.sv
// Lane-serial packed SIMD subtractor: c = a - b over 8/16/32-bit elements, one byte per cycle,
// with per-element signed overflow detection and optional saturation.
module packed_sub_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  width,
    input  logic        saturate,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] c,
    output logic [3:0]  ovf
);

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StB0   = 3'd1,
        StB1   = 3'd2,
        StB2   = 3'd3,
        StB3   = 3'd4,
        StSat  = 3'd5,
        StDone = 3'd6
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [1:0]  width_q, width_d;
    logic        sat_q, sat_d;
    logic [31:0] res_q, res_d;
    logic        carry_q, carry_d;
    logic [3:0]  sign_a_q, sign_a_d;
    logic [3:0]  sign_b_q, sign_b_d;
    logic [3:0]  sign_s_q, sign_s_d;
    logic [31:0] c_q, c_d;
    logic [3:0]  ovf_q, ovf_d;

    logic [1:0]  byte_idx;
    logic [7:0]  a_byte;
    logic [7:0]  b_byte;
    logic        cin;
    logic [8:0]  sum9;

    logic [3:0]  is_top;
    logic [3:0]  lane_ovf;
    logic [3:0]  sat_ovf;
    logic [31:0] sat_c;

    // Byte slice datapath: a + ~b + cin, borrow chained only inside an element.
    always_comb begin
        byte_idx = 2'd0;
        unique case (state_q)
            StB1:    byte_idx = 2'd1;
            StB2:    byte_idx = 2'd2;
            StB3:    byte_idx = 2'd3;
            default: byte_idx = 2'd0;
        endcase
        a_byte = a_q[{byte_idx, 3'b000} +: 8];
        b_byte = b_q[{byte_idx, 3'b000} +: 8];
        if (byte_idx == 2'd0 || width_q == 2'b00 || (byte_idx == 2'd2 && width_q == 2'b01)) begin
            cin = 1'b1;
        end else begin
            cin = carry_q;
        end
        sum9 = {1'b0, a_byte} + {1'b0, ~b_byte} + {8'd0, cin};
    end

    // Overflow and saturation; each lane looks up the top byte of its own element.
    always_comb begin
        unique case (width_q)
            2'b00:   is_top = 4'b1111;
            2'b01:   is_top = 4'b1010;
            default: is_top = 4'b1000;
        endcase
        lane_ovf = (sign_a_q ^ sign_b_q) & (sign_s_q ^ sign_a_q);
        sat_ovf  = lane_ovf & is_top;
        sat_c    = res_q;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] li;
            logic [1:0] top;
            li = 2'(i);
            unique case (width_q)
                2'b00:   top = li;
                2'b01:   top = {li[1], 1'b1};
                default: top = 2'd3;
            endcase
            if (sat_q && lane_ovf[top]) begin
                if (li == top) begin
                    sat_c[8*i +: 8] = sign_a_q[top] ? 8'h80 : 8'h7F;
                end else begin
                    sat_c[8*i +: 8] = sign_a_q[top] ? 8'h00 : 8'hFF;
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        width_d  = width_q;
        sat_d    = sat_q;
        res_d    = res_q;
        carry_d  = carry_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        sign_s_d = sign_s_q;
        c_d      = c_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    width_d = width;
                    sat_d   = saturate;
                    res_d   = 32'd0;
                    state_d = StB0;
                end
            end
            StB0, StB1, StB2, StB3: begin
                res_d[{byte_idx, 3'b000} +: 8] = sum9[7:0];
                carry_d                       = sum9[8];
                sign_a_d[byte_idx]            = a_byte[7];
                sign_b_d[byte_idx]            = b_byte[7];
                sign_s_d[byte_idx]            = sum9[7];
                state_d                       = state_e'(state_q + 3'd1);
            end
            StSat: begin
                c_d     = sat_c;
                ovf_d   = sat_ovf;
                state_d = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            width_q  <= 2'd0;
            sat_q    <= 1'b0;
            res_q    <= 32'd0;
            carry_q  <= 1'b0;
            sign_a_q <= 4'd0;
            sign_b_q <= 4'd0;
            sign_s_q <= 4'd0;
            c_q      <= 32'd0;
            ovf_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            width_q  <= width_d;
            sat_q    <= sat_d;
            res_q    <= res_d;
            carry_q  <= carry_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            sign_s_q <= sign_s_d;
            c_q      <= c_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign c         = c_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_packed_sub_seq.sv
// Directed bench for packed_sub_seq: expected results are queued at issue and checked when
// out_valid appears, alongside latency, backpressure and reset behaviour.
module tb_packed_sub_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  width;
    logic        saturate;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] c;
    logic [3:0]  ovf;

    typedef struct packed {
        logic [31:0] c;
        logic [3:0]  o;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    packed_sub_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .width     (width),
        .saturate  (saturate),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: element-wise signed difference in wide arithmetic, then clamp or wrap.
    function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb,
                                   input logic [1:0] mw, input logic ms);
        exp_t   r;
        int     n;
        longint full, half, mask, ua, ub, sa, sb, d;
        r = '0;
        n = (mw == 2'b00) ? 8 : (mw == 2'b01) ? 16 : 32;
        full = longint'(1) << n;
        half = full >> 1;
        mask = full - 1;
        for (int off = 0; off < 32; off += n) begin
            ua = (longint'(ma) >> off) & mask;
            ub = (longint'(mb) >> off) & mask;
            sa = (ua >= half) ? ua - full : ua;
            sb = (ub >= half) ? ub - full : ub;
            d  = sa - sb;
            if (d > half - 1 || d < -half) begin
                r.o[(off + n) / 8 - 1] = 1'b1;
                if (ms) d = (d > 0) ? half - 1 : -half;
            end
            r.c = r.c | 32'((d & mask) << off);
        end
        return r;
    endfunction

    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input logic [1:0] tw,
                          input logic ts, input exp_t e, input int hold, input string tag);
        int   lat;
        exp_t got;
        logic [31:0] held_c;
        logic [3:0]  held_o;
        @(negedge clk);
        a         = ta;
        b         = tb;
        width     = tw;
        saturate  = ts;
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        exp_q.push_back(e);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = ~ta;
        b        = ~tb;
        lat      = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 20);
        chk({tag, "_latency"}, 32'(lat), 32'd5);
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 32'd1, 32'd0);
            got = '0;
        end else begin
            got = exp_q.pop_front();
        end
        chk({tag, "_c"}, c, got.c);
        chk({tag, "_ovf"}, 32'(ovf), 32'(got.o));
        held_c = c;
        held_o = ovf;
        for (int k = 0; k < hold; k++) begin
            in_valid = (k == 1);
            a        = $urandom;
            b        = $urandom;
            @(posedge clk);
            #1;
            chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_c"}, c, held_c);
            chk({tag, "_hold_ovf"}, 32'(ovf), 32'(held_o));
            chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, "_xfer_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_xfer_in_ready"}, 32'(in_ready), 32'd1);
        if (hold > 0) begin
            repeat (8) @(posedge clk);
            #1;
            chk({tag, "_no_ghost"}, 32'(out_valid), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [1:0]  rw;
        logic        rs;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        width     = '0;
        saturate  = 1'b0;
        out_ready = 1'b1;
        #13;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_c", c, 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(32'h01020304, 32'h01010101, 2'b00, 1'b0, '{32'h00010203, 4'b0000}, 0, "w8");
        run_op(32'h807F0005, 32'h01FF010A, 2'b00, 1'b1, '{32'h807FFFFB, 4'b1100}, 0, "w8sat");
        run_op(32'h807F0005, 32'h01FF010A, 2'b00, 1'b0, '{32'h7F80FFFB, 4'b1100}, 0, "w8wrap");
        run_op(32'h00010000, 32'h00000001, 2'b01, 1'b0, '{32'h0001FFFF, 4'b0000}, 0, "iso16");
        run_op(32'h00010000, 32'h00000001, 2'b10, 1'b0, '{32'h0000FFFF, 4'b0000}, 0, "iso32");
        run_op(32'h00010000, 32'h00000001, 2'b11, 1'b0, '{32'h0000FFFF, 4'b0000}, 0, "iso32b");
        run_op(32'h80000000, 32'h00000001, 2'b10, 1'b1, '{32'h80000000, 4'b1000}, 0, "w32sat");
        run_op(32'h80000000, 32'h00000001, 2'b10, 1'b0, '{32'h7FFFFFFF, 4'b1000}, 0, "w32wrap");
        run_op(32'h7FFF8000, 32'hFFFF0001, 2'b01, 1'b1, '{32'h7FFF8000, 4'b1010}, 0, "w16sat");
        run_op(32'h01020304, 32'h05060708, 2'b00, 1'b0, model(32'h01020304, 32'h05060708,
               2'b00, 1'b0), 3, "bp");

        // Abort an operation while it sits in the third byte slice.
        @(negedge clk);
        a        = 32'h12345678;
        b        = 32'h00000001;
        width    = 2'b10;
        saturate = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_c", c, 32'd0);
        chk("midrst_ovf", 32'(ovf), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("midrst_discard", 32'(out_valid), 32'd0);
        run_op(32'h7FFF8000, 32'hFFFF0001, 2'b01, 1'b1, '{32'h7FFF8000, 4'b1010}, 0, "postrst");

        for (int i = 0; i < 12; i++) begin
            ra = $urandom;
            rb = $urandom;
            rw = 2'($urandom_range(0, 3));
            rs = 1'($urandom_range(0, 1));
            run_op(ra, rb, rw, rs, model(ra, rb, rw, rs), (i % 4 == 3) ? 2 : 0, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/packed_sub_seq.md
# packed_sub_seq

Lane-serial packed SIMD subtractor, the subtract-direction counterpart of the packed saturating adder in the datapath. It computes c = a − b on a 32-bit word split into 8-, 16- or 32-bit elements, with optional per-element signed saturation. One byte slice is processed per cycle, and the borrow is carried between cycles only within an element. Operands enter and results leave through valid/ready handshakes, so the block can sit between an operand register stage and a writeback stage.

## Interface
- No parameters; datapath fixed at 32 bits, 4 byte lanes.
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand set offered.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  32  minuend, packed.
- b  input  32  subtrahend, packed.
- width  input  2  element size: 00 = 8-bit, 01 = 16-bit, 10 = 32-bit, 11 = 32-bit.
- saturate  input  1  1 = clamp signed-overflowed elements.
- out_valid  output  1  result held on c/ovf.
- out_ready  input  1  consumer takes the result.
- c  output  32  packed difference, registered.
- ovf  output  4  per-lane signed-overflow flag; bit i is set only if lane i is the top byte of an overflowed element.

## Operation
- States: IDLE → B0 → B1 → B2 → B3 → SAT → DONE → IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid, latch a, b, width and saturate, clear the result register, and go to B0.
  - Later changes on the inputs are ignored.
- Bi (i = 0..3):
  - Compute byte i as a_i + ~b_i + cin_i.
  - Store the sum in result byte i. Store carry-out, and the sign bits of a_i, b_i and the sum.
  - cin_i = 1 when byte i starts an element: i = 0; any i for width 00; i = 2 for width 01. Otherwise cin_i is the carry-out of byte i−1.
- SAT:
  - For each element, with top byte t: overflow = (sign a_t ≠ sign b_t) and (sign sum_t ≠ sign a_t).
  - ovf[t] = overflow, whether or not saturate is set.
  - If saturate and overflow: the element becomes 0x7F…FF when sign a_t = 0, or 0x80…00 when sign a_t = 1.
  - Register c and ovf, and set out_valid.
- DONE:
  - out_valid = 1; c and ovf are held stable.
  - On out_ready, clear out_valid and go to IDLE.
- Reset, including mid-operation:
  - State goes to IDLE and the operation in progress is discarded.
  - out_valid = 0, c = 0, ovf = 0, in_ready = 1.

## Timing
- Acceptance happens at the rising edge T where in_valid & in_ready.
- Bytes 0..3 are written at edges T+1..T+4. Saturation, c/ovf and out_valid are written at edge T+5.
- Latency is 5 cycles from acceptance to out_valid.
- If out_ready is already high, the output transfer occurs at edge T+6, and in_ready rises after that edge.
- Minimum issue interval is 7 cycles.
- in_ready is combinational from state only, with no dependency on in_valid.
- out_valid never drops without a handshake except on rst.
- A held out_ready never causes more than one transfer per result.

## Test plan
- Width 00, no saturation: a = 0x01020304, b = 0x01010101 → c = 0x00010203, ovf = 0000, out_valid 5 cycles after acceptance.
- Width 00, saturate = 1: a = 0x807F0005, b = 0x01FF010A → c = 0x807FFFFB, ovf = 1100. With saturate = 0 → c = 0x7F80FFFB, ovf = 1100.
- Borrow isolation:
  - a = 0x00010000, b = 0x00000001, width 01 → c = 0x0001FFFF, ovf = 0000.
  - Same operands, width 10 or 11 → c = 0x0000FFFF.
- Width 10 overflow: a = 0x80000000, b = 0x00000001:
  - saturate = 1 → c = 0x80000000, ovf = 1000.
  - saturate = 0 → c = 0x7FFFFFFF, ovf = 1000.
  - Width 01, a = 0x7FFF8000, b = 0xFFFF0001, saturate = 1 → c = 0x7FFF8000, ovf = 1010.
- Backpressure:
  - Hold out_ready low for 3 cycles after out_valid; c and ovf stay stable and in_ready stays 0.
  - Changing a/b and pulsing in_valid in this window has no effect.
  - Raise out_ready: one transfer, then in_ready = 1.
- Reset mid-operation: assert rst asynchronously while in B2 → out_valid = 0, c = 0, ovf = 0 and in_ready = 1 immediately. The next operation produces a correct result.
